// File: rtl/window_fetch_controller_if.sv
// window_fetch_controller_if: request, ROM read and pixel stream signals of the window fetcher.
interface window_fetch_controller_if #(
    parameter int DATA_WIDTH_8 = 8,
    parameter int DATA_WIDTH_16 = 16
);
    logic start;
    logic [DATA_WIDTH_16-1:0] ori_x;
    logic [DATA_WIDTH_16-1:0] ori_y;
    logic [DATA_WIDTH_16-1:0] frame_width;
    logic [DATA_WIDTH_16-1:0] frame_height;
    logic stall;
    logic rom_enable;
    logic [DATA_WIDTH_16-1:0] rom_address;
    logic [DATA_WIDTH_8-1:0] rom_q;
    logic [DATA_WIDTH_8-1:0] o_pixel;
    logic o_pixel_valid;
    logic o_last;
    logic o_busy;
    logic o_done;
    logic o_error;
    modport master (
        output start, ori_x, ori_y, frame_width, frame_height, stall, rom_q,
        input rom_enable, rom_address, o_pixel, o_pixel_valid, o_last, o_busy, o_done, o_error
    );
    modport slave (
        input start, ori_x, ori_y, frame_width, frame_height, stall, rom_q,
        output rom_enable, rom_address, o_pixel, o_pixel_valid, o_last, o_busy, o_done, o_error
    );
endinterface

// File: rtl/window_fetch_controller.sv
// window_fetch_controller: streams a WINDOW_SIZE x WINDOW_SIZE pixel window from an image ROM in row-major order.
module window_fetch_controller #(
    parameter int DATA_WIDTH_8 = 8,
    parameter int DATA_WIDTH_16 = 16,
    parameter int WINDOW_SIZE = 24
) (
    input logic clk,
    input logic reset,
    window_fetch_controller_if.slave bus
);
    localparam int CW = $clog2(WINDOW_SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(WINDOW_SIZE - 1);
    localparam logic [DATA_WIDTH_16:0] WS = (DATA_WIDTH_16 + 1)'(WINDOW_SIZE);
    typedef enum logic [2:0] {IDLE, SETUP, FETCH, DRAIN, DONE} state_t;
    state_t state, next;
    logic [DATA_WIDTH_16-1:0] ox, oy, fw, row_base;
    logic [CW-1:0] row, col;
    logic valid, last, bad, wrap, fin, issue;
    // 17-bit compare so an origin near 2^16 cannot wrap into range
    assign bad = ({1'b0, bus.ori_x} + WS > {1'b0, bus.frame_width}) ||
                 ({1'b0, bus.ori_y} + WS > {1'b0, bus.frame_height});
    assign wrap = col == LAST;
    assign fin = wrap && row == LAST;
    assign bus.rom_address = state == FETCH ? row_base + DATA_WIDTH_16'(col) : '0;
    assign bus.o_pixel = valid ? bus.rom_q : {DATA_WIDTH_8{1'b0}};
    assign bus.o_pixel_valid = valid;
    assign bus.o_last = last;
    assign bus.rom_enable = issue;
    always_ff @(posedge clk) begin
        state <= !reset ? IDLE : next;
    end
    always_comb begin
        next = state;
        issue = 1'b0;
        bus.o_busy = state != IDLE;
        bus.o_done = state == DONE;
        unique case (state)
            IDLE: next = bus.start && !bad ? SETUP : IDLE;
            SETUP: next = FETCH;
            FETCH: begin
                issue = !bus.stall;
                next = issue && fin ? DRAIN : FETCH;
            end
            DRAIN: next = DONE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            ox <= '0;
            oy <= '0;
            fw <= '0;
            row_base <= '0;
            row <= '0;
            col <= '0;
            valid <= 1'b0;
            last <= 1'b0;
            bus.o_error <= 1'b0;
        end else begin
            valid <= issue;
            last <= issue && fin;
            bus.o_error <= state == IDLE && bus.start && bad;
            if (state == IDLE && bus.start) begin
                ox <= bus.ori_x;
                oy <= bus.ori_y;
                fw <= bus.frame_width;
            end
            if (state == SETUP) begin
                row_base <= oy * fw + ox;
                row <= '0;
                col <= '0;
            end else if (issue) begin
                col <= wrap ? '0 : col + 1'b1;
                row <= wrap ? row + 1'b1 : row;
                row_base <= wrap ? row_base + fw : row_base;
            end
        end
    end
endmodule

// File: tb/tb_window_fetch_controller.sv
// tb_window_fetch_controller: randomized window fetches checked against a row-major address/pixel model.
module tb_window_fetch_controller;
    localparam int W = 24;
    localparam int N = W * W;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    window_fetch_controller_if bus ();
    window_fetch_controller #(.DATA_WIDTH_8(8), .DATA_WIDTH_16(16), .WINDOW_SIZE(W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    int pass_n = 0;
    int total_n = 0;
    logic [15:0] got_addr[$];
    logic [7:0] got_pix[$];
    int last_idx, last_cnt, done_cyc, done_cnt, err_cyc, err_cnt, busy_cnt;
    int stall_en, stall_cyc, stall_valid, last_valid_cyc;

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5a;
    endfunction

    // window pixel i sits at (ox + i%W, oy + i/W) in a row-major frame of width fw
    function automatic logic [15:0] exp_addr(input int ox, input int oy, input int fw, input int i);
        longint v;
        v = longint'(oy + i / W) * longint'(fw) + longint'(ox + i % W);
        return v[15:0];
    endfunction

    function automatic int addr_errs(input int ox, input int oy, input int fw);
        int e = 0;
        for (int i = 0; i < got_addr.size(); i++) if (got_addr[i] !== exp_addr(ox, oy, fw, i)) e++;
        return e;
    endfunction

    function automatic int pix_errs(input int ox, input int oy, input int fw);
        int e = 0;
        for (int i = 0; i < got_pix.size(); i++) if (got_pix[i] !== rom_fn(exp_addr(ox, oy, fw, i))) e++;
        return e;
    endfunction

    always @(posedge clk) if (bus.rom_enable) bus.rom_q <= rom_fn(bus.rom_address);

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // mode 0: no stall, 1: five stall cycles after 11 issued reads, 2: random stall
    task automatic run_window(input int ox, input int oy, input int fw, input int fh,
                              input int mode, input bit restart, input bit expect_err);
        int issued = 0;
        int limit = expect_err ? 8 : 3000;
        got_addr.delete();
        got_pix.delete();
        last_idx = -1; last_cnt = 0; done_cyc = -1; done_cnt = 0; err_cyc = -1; err_cnt = 0;
        busy_cnt = 0; stall_en = 0; stall_cyc = 0; stall_valid = 0; last_valid_cyc = -1;
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1;
        bus.stall = 1'b0;
        bus.ori_x = 16'(ox);
        bus.ori_y = 16'(oy);
        bus.frame_width = 16'(fw);
        bus.frame_height = 16'(fh);
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            bus.start = restart && (cyc == 50 || cyc == 300);
            {bus.ori_x, bus.ori_y} = $urandom;
            {bus.frame_width, bus.frame_height} = $urandom;
            bus.stall = mode == 1 ? (issued == 11 && stall_cyc < 5) :
                        mode == 2 ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            if (mode == 1 && bus.stall) stall_cyc++;
            if (bus.stall && bus.rom_enable) stall_en++;
            if (mode == 1 && bus.stall && bus.o_pixel_valid) stall_valid++;
            if (bus.rom_enable) begin
                got_addr.push_back(bus.rom_address);
                issued++;
            end
            if (bus.o_pixel_valid) begin
                got_pix.push_back(bus.o_pixel);
                last_valid_cyc = cyc;
                if (bus.o_last) last_idx = got_pix.size() - 1;
            end
            if (bus.o_last) last_cnt++;
            if (bus.o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (bus.o_error) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (bus.o_busy) busy_cnt++;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.ori_x = '0; bus.ori_y = '0; bus.frame_width = '0; bus.frame_height = '0;
        repeat (3) @(negedge clk);
        #1;
        total_n++; if (bus.rom_address !== 16'd0) $display("FAIL reset_rom_address got %0d want 0", bus.rom_address); else pass_n++;
        total_n++; if (bus.o_pixel !== 8'd0) $display("FAIL reset_o_pixel got %0d want 0", bus.o_pixel); else pass_n++;
        total_n++; if ({bus.rom_enable, bus.o_pixel_valid, bus.o_last, bus.o_busy, bus.o_done, bus.o_error} !== 6'd0)
            $display("FAIL reset_flags got %b want 000000",
                     {bus.rom_enable, bus.o_pixel_valid, bus.o_last, bus.o_busy, bus.o_done, bus.o_error});
        else pass_n++;
    endtask

    task automatic test_basic();
        run_window(10, 5, 320, 240, 0, 1'b0, 1'b0);
        total_n++; if (got_addr.size() !== N) $display("FAIL basic_addr_count got %0d want %0d", got_addr.size(), N); else pass_n++;
        total_n++; if (got_addr[0] !== 16'd1610) $display("FAIL basic_first_addr got %0d want 1610", got_addr[0]); else pass_n++;
        total_n++; if (got_addr[23] !== 16'd1633) $display("FAIL basic_row0_end got %0d want 1633", got_addr[23]); else pass_n++;
        total_n++; if (got_addr[24] !== 16'd1930) $display("FAIL basic_row1_start got %0d want 1930", got_addr[24]); else pass_n++;
        total_n++; if (got_addr[N-1] !== 16'd8993) $display("FAIL basic_last_addr got %0d want 8993", got_addr[N-1]); else pass_n++;
        total_n++; if (addr_errs(10, 5, 320) !== 0) $display("FAIL basic_addr_order got %0d bad want 0", addr_errs(10, 5, 320)); else pass_n++;
        total_n++; if (got_pix.size() !== N) $display("FAIL basic_valid_count got %0d want %0d", got_pix.size(), N); else pass_n++;
        total_n++; if (pix_errs(10, 5, 320) !== 0) $display("FAIL basic_pixels got %0d bad want 0", pix_errs(10, 5, 320)); else pass_n++;
        total_n++; if (last_idx !== N - 1 || last_cnt !== 1) $display("FAIL basic_last got idx %0d cnt %0d want %0d 1", last_idx, last_cnt, N - 1); else pass_n++;
        total_n++; if (done_cyc !== N + 3 || done_cnt !== 1) $display("FAIL basic_done got cyc %0d cnt %0d want %0d 1", done_cyc, done_cnt, N + 3); else pass_n++;
        total_n++; if (busy_cnt !== N + 3) $display("FAIL basic_busy got %0d want %0d", busy_cnt, N + 3); else pass_n++;
        total_n++; if (err_cnt !== 0) $display("FAIL basic_error got %0d want 0", err_cnt); else pass_n++;
    endtask

    task automatic test_bounds();
        run_window(296, 5, 320, 240, 0, 1'b0, 1'b0);
        total_n++; if (err_cnt !== 0 || got_pix.size() !== N) $display("FAIL edge_accept got err %0d valids %0d want 0 %0d", err_cnt, got_pix.size(), N); else pass_n++;
        total_n++; if (addr_errs(296, 5, 320) !== 0) $display("FAIL edge_addr got %0d bad want 0", addr_errs(296, 5, 320)); else pass_n++;
        run_window(297, 5, 320, 240, 0, 1'b0, 1'b1);
        total_n++; if (err_cnt !== 1 || err_cyc !== 1) $display("FAIL x_error got cnt %0d cyc %0d want 1 1", err_cnt, err_cyc); else pass_n++;
        total_n++; if (busy_cnt !== 0 || got_addr.size() !== 0) $display("FAIL x_reject got busy %0d reads %0d want 0 0", busy_cnt, got_addr.size()); else pass_n++;
        run_window(0, 217, 320, 240, 0, 1'b0, 1'b1);
        total_n++; if (err_cnt !== 1 || busy_cnt !== 0 || done_cnt !== 0) $display("FAIL y_error got err %0d busy %0d done %0d want 1 0 0", err_cnt, busy_cnt, done_cnt); else pass_n++;
    endtask

    task automatic test_stall();
        run_window(10, 5, 320, 240, 1, 1'b0, 1'b0);
        total_n++; if (stall_cyc !== 5 || stall_en !== 0) $display("FAIL stall_hold got stalls %0d reads %0d want 5 0", stall_cyc, stall_en); else pass_n++;
        total_n++; if (stall_valid !== 1) $display("FAIL stall_inflight got %0d want 1", stall_valid); else pass_n++;
        total_n++; if (got_addr[11] !== 16'd1621) $display("FAIL stall_resume got %0d want 1621", got_addr[11]); else pass_n++;
        total_n++; if (addr_errs(10, 5, 320) !== 0 || got_addr.size() !== N) $display("FAIL stall_addr got %0d bad of %0d", addr_errs(10, 5, 320), got_addr.size()); else pass_n++;
        total_n++; if (got_pix.size() !== N || pix_errs(10, 5, 320) !== 0) $display("FAIL stall_pixels got %0d valids %0d bad", got_pix.size(), pix_errs(10, 5, 320)); else pass_n++;
        total_n++; if (done_cyc !== N + 8) $display("FAIL stall_done got %0d want %0d", done_cyc, N + 8); else pass_n++;
    endtask

    task automatic test_back_to_back_start();
        run_window(10, 5, 320, 240, 0, 1'b1, 1'b0);
        total_n++; if (got_pix.size() !== N || pix_errs(10, 5, 320) !== 0) $display("FAIL restart_pixels got %0d valids %0d bad", got_pix.size(), pix_errs(10, 5, 320)); else pass_n++;
        total_n++; if (done_cyc !== N + 3 || done_cnt !== 1) $display("FAIL restart_done got cyc %0d cnt %0d want %0d 1", done_cyc, done_cnt, N + 3); else pass_n++;
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1;
        bus.ori_x = 16'd10; bus.ori_y = 16'd5; bus.frame_width = 16'd320; bus.frame_height = 16'd240;
        for (int cyc = 1; cyc < 2000 && nv < 100; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.o_pixel_valid) nv++;
        end
        total_n++; if (nv !== 100) $display("FAIL midreset_reach got %0d valids want 100", nv); else pass_n++;
        reset = 1'b0;
        @(negedge clk);
        #1;
        total_n++; if ({bus.rom_enable, bus.o_pixel_valid, bus.o_last, bus.o_busy, bus.o_done, bus.o_error} !== 6'd0 ||
                       bus.rom_address !== 16'd0 || bus.o_pixel !== 8'd0)
            $display("FAIL midreset_outputs got %b addr %0d pix %0d want 0",
                     {bus.rom_enable, bus.o_pixel_valid, bus.o_last, bus.o_busy, bus.o_done, bus.o_error},
                     bus.rom_address, bus.o_pixel);
        else pass_n++;
        run_window(10, 5, 320, 240, 0, 1'b0, 1'b0);
        total_n++; if (got_addr.size() !== N || addr_errs(10, 5, 320) !== 0) $display("FAIL midreset_refetch got %0d reads %0d bad", got_addr.size(), addr_errs(10, 5, 320)); else pass_n++;
        total_n++; if (done_cyc !== N + 3 || last_idx !== N - 1) $display("FAIL midreset_done got cyc %0d last %0d want %0d %0d", done_cyc, last_idx, N + 3, N - 1); else pass_n++;
    endtask

    task automatic test_small_frame();
        int e = 0;
        run_window(0, 0, 24, 24, 0, 1'b0, 1'b0);
        for (int i = 0; i < got_addr.size(); i++) if (got_addr[i] !== 16'(i)) e++;
        total_n++; if (got_addr.size() !== N || e !== 0) $display("FAIL small_contig got %0d reads %0d bad want %0d 0", got_addr.size(), e, N); else pass_n++;
        total_n++; if (err_cnt !== 0 || done_cnt !== 1) $display("FAIL small_status got err %0d done %0d want 0 1", err_cnt, done_cnt); else pass_n++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            int fw = $urandom_range(24, 5000);
            int fh = $urandom_range(24, 65535);
            int ox = $urandom_range(0, fw - W);
            int oy = $urandom_range(0, fh - W);
            run_window(ox, oy, fw, fh, 2, k[0], 1'b0);
            total_n++; if (got_addr.size() !== N || addr_errs(ox, oy, fw) !== 0) $display("FAIL rand%0d_addr got %0d reads %0d bad", k, got_addr.size(), addr_errs(ox, oy, fw)); else pass_n++;
            total_n++; if (got_pix.size() !== N || pix_errs(ox, oy, fw) !== 0) $display("FAIL rand%0d_pixels got %0d valids %0d bad", k, got_pix.size(), pix_errs(ox, oy, fw)); else pass_n++;
            total_n++; if (last_idx !== N - 1 || last_cnt !== 1) $display("FAIL rand%0d_last got idx %0d cnt %0d", k, last_idx, last_cnt); else pass_n++;
            total_n++; if (done_cyc !== last_valid_cyc + 1 || done_cnt !== 1) $display("FAIL rand%0d_done got %0d want %0d", k, done_cyc, last_valid_cyc + 1); else pass_n++;
        end
        begin
            int fw = $urandom_range(24, 5000);
            int ox = fw - W + $urandom_range(1, 20);
            run_window(ox, 0, fw, 100, 0, 1'b0, 1'b1);
            total_n++; if (err_cnt !== 1 || got_addr.size() !== 0) $display("FAIL rand_reject got err %0d reads %0d want 1 0", err_cnt, got_addr.size()); else pass_n++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounds();
        test_stall();
        test_back_to_back_start();
        test_reset_mid();
        test_small_frame();
        test_random();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
